tetris_input_ctrl: RTL and testbench
====================================

TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, cycles a raw button must be stable before its debounced level changes.
REQ-002 Parameter GRAVITY_BASE, default 100000000, gravity period in cycles at level 0.
REQ-003 Parameter STALL_CYCLES, default 1024, cycles of continuous ready=0 after which a pending user event is issued anyway (wakes game from INIT/END).
REQ-004 Parameter REPEAT_DELAY, default 30000000; REPEAT_PERIOD, default 10000000 (auto-repeat timing).
REQ-005 clk  input  1  clock; all logic on posedge clk.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 btn  input  4  raw async buttons: [0] LEFT, [1] RIGHT, [2] ROTATE, [3] DROP.
REQ-008 rx_data  input  8  received UART byte; rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-009 level  input  4  gravity speed level.
REQ-010 ready  input  1  game-core ready flag (high only while core waits for a command).
REQ-011 ctrl  output  control_type  registered command to game core; NONE (0) when idle.

Function
REQ-012 Each btn bit passes a 2-flop synchronizer, then a debouncer; a debounced 0->1 transition sets that command's pending bit.
REQ-013 rx_valid with rx_data 'a','d','s',' ','c','w','z','b' sets pending LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR respectively; any other byte ignored.
REQ-014 One pending bit per command (8 bits); setting an already-set bit has no further effect (events coalesce).
REQ-015 Gravity counter increments every cycle; on reaching max(1, GRAVITY_BASE >> level) - 1 it reloads to 0 and sets pending DOWN.
REQ-016 Gravity counter reloads to 0 whenever DOWN is issued on ctrl (user or gravity).
REQ-017 Issue rule: when ready=1, ctrl==NONE and any pending bit set, ctrl <= highest-priority pending command for exactly one cycle, then NONE.
REQ-018 Priority: DROP > HOLD > ROTATE > ROTATE_REV > LEFT > RIGHT > BAR > DOWN.
REQ-019 Issued command's pending bit clears the same cycle ctrl is loaded; a new event for that command in the same cycle wins (bit stays set).
REQ-020 Stall counter counts cycles with ready=0, cleared when ready=1; at STALL_CYCLES, if any non-DOWN pending bit is set, issue it per REQ-017 priority (DOWN excluded), then clear the stall counter.
REQ-021 ctrl never non-NONE in two consecutive cycles.
REQ-022 Issue latency: command visible on ctrl one cycle after the cycle ready=1 and pending bit both observed.

Reset
REQ-023 reset_n=0 at a clock edge: ctrl=NONE, all pending bits 0, gravity/stall/repeat counters 0, debounced levels 0, synchronizers 0; reset mid-operation discards pending events.

Configuration
REQ-024 Macro TETRIS_AUTO_REPEAT_EN defined: LEFT/RIGHT debounced-held for REPEAT_DELAY sets the pending bit again, then every REPEAT_PERIOD while held; release stops repeat and clears repeat counter.
REQ-025 Macro undefined: only debounced rising edges generate button events; repeat counters absent.

Structure
REQ-026 Package control_pkg holds control_type enum (NONE=0, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR) and the UART key constants; shared with the game core.
REQ-027 Sub-module btn_debounce (synchronizer + stable counter, parameter DEBOUNCE_CYCLES), instantiated four times.

Verification (DEBOUNCE_CYCLES=4, GRAVITY_BASE=64, STALL_CYCLES=16, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 btn[0] high 10 cycles, ready=1 -> exactly one ctrl=LEFT pulse; 2-cycle glitch -> no pulse.
REQ-029 rx 'w' and ' ' in same window, ready=1 -> DROP issued first, ROTATE after ready re-asserts.
REQ-030 level=2, no input, ready=1 -> ctrl=DOWN every 16 cycles; user 's' resets the 16-cycle interval.
REQ-031 ready=0 held, rx 'c' -> ctrl=HOLD after 16 stall cycles; gravity DOWN alone never issued while ready=0.
REQ-032 TETRIS_AUTO_REPEAT_EN, btn[1] held 50 cycles, ready=1 -> RIGHT at debounce, again ~20 cycles later, then every 8.
REQ-033 reset_n=0 with pending DROP -> ctrl stays NONE after reset released.

Source files
------------

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - command encoding, UART key codes and pending-set helpers shared with the game core
package control_pkg;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8
    } control_type;

    localparam logic [7:0] KEY_LEFT       = 8'h61;
    localparam logic [7:0] KEY_RIGHT      = 8'h64;
    localparam logic [7:0] KEY_DOWN       = 8'h73;
    localparam logic [7:0] KEY_DROP       = 8'h20;
    localparam logic [7:0] KEY_HOLD       = 8'h63;
    localparam logic [7:0] KEY_ROTATE     = 8'h77;
    localparam logic [7:0] KEY_ROTATE_REV = 8'h7a;
    localparam logic [7:0] KEY_BAR        = 8'h62;

    // Pending bit i holds the command whose enum value is i+1.
    localparam int BIT_LEFT       = 0;
    localparam int BIT_RIGHT      = 1;
    localparam int BIT_DOWN       = 2;
    localparam int BIT_DROP       = 3;
    localparam int BIT_HOLD       = 4;
    localparam int BIT_ROTATE     = 5;
    localparam int BIT_ROTATE_REV = 6;
    localparam int BIT_BAR        = 7;

    function automatic logic [7:0] cmd_bit(input control_type c);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (int'(c) == i + 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic control_type pick_cmd(input logic [7:0] p);
        control_type c;
        c = NONE;
        if      (p[BIT_DROP])       c = DROP;
        else if (p[BIT_HOLD])       c = HOLD;
        else if (p[BIT_ROTATE])     c = ROTATE;
        else if (p[BIT_ROTATE_REV]) c = ROTATE_REV;
        else if (p[BIT_LEFT])       c = LEFT;
        else if (p[BIT_RIGHT])      c = RIGHT;
        else if (p[BIT_BAR])        c = BAR;
        else if (p[BIT_DOWN])       c = DOWN;
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer plus stable-count debouncer for one raw button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The level flips only after the synchronized input has differed from it
    // for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - merges buttons, UART keys and gravity into one-shot game commands; TETRIS_AUTO_REPEAT_EN enables LEFT/RIGHT auto-repeat
module tetris_input_ctrl
    import control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GRAVITY_BASE    = 100000000,
    parameter int STALL_CYCLES    = 1024,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  btn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [3:0]  level,
    input  logic        ready,
    output control_type ctrl
);

    localparam int GW = $clog2(GRAVITY_BASE + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    logic [3:0]    deb_level;
    logic [3:0]    deb_prev;
    logic [3:0]    deb_rise;
    logic [7:0]    pending;
    logic [7:0]    uart_set;
    logic [7:0]    btn_set;
    logic [7:0]    grav_set;
    logic [7:0]    rep_set;
    logic [7:0]    set_mask;
    logic [7:0]    clr_mask;
    logic [7:0]    non_down;
    logic [GW-1:0] grav_cnt;
    logic [GW-1:0] grav_limit;
    logic [31:0]   grav_shift;
    logic          grav_tick;
    logic [SW-1:0] stall_cnt;
    logic          stall_hit;
    logic          issue_normal;
    logic          issue_stall;
    logic          issue;
    logic          down_issued;
    control_type   issue_cmd;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn[i]),
            .level  (deb_level[i])
        );
    end

    assign deb_rise = deb_level & ~deb_prev;

    always_comb begin
        uart_set = '0;
        if (rx_valid) begin
            case (rx_data)
                KEY_LEFT:       uart_set[BIT_LEFT]       = 1'b1;
                KEY_RIGHT:      uart_set[BIT_RIGHT]      = 1'b1;
                KEY_DOWN:       uart_set[BIT_DOWN]       = 1'b1;
                KEY_DROP:       uart_set[BIT_DROP]       = 1'b1;
                KEY_HOLD:       uart_set[BIT_HOLD]       = 1'b1;
                KEY_ROTATE:     uart_set[BIT_ROTATE]     = 1'b1;
                KEY_ROTATE_REV: uart_set[BIT_ROTATE_REV] = 1'b1;
                KEY_BAR:        uart_set[BIT_BAR]        = 1'b1;
                default:        uart_set                 = '0;
            endcase
        end
    end

    always_comb begin
        btn_set             = '0;
        btn_set[BIT_LEFT]   = deb_rise[0];
        btn_set[BIT_RIGHT]  = deb_rise[1];
        btn_set[BIT_ROTATE] = deb_rise[2];
        btn_set[BIT_DROP]   = deb_rise[3];
    end

`ifdef TETRIS_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep_phase;
    logic [1:0]    rep_fire;

    // rep_cnt is cycles held since the rising edge (phase 0) or since the last repeat (phase 1).
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            rep_fire[j] = deb_level[j] &&
                          (rep_phase[j] ? (rep_cnt[j] == RW'(REPEAT_PERIOD))
                                        : (rep_cnt[j] == RW'(REPEAT_DELAY)));
        end
        rep_set            = '0;
        rep_set[BIT_LEFT]  = rep_fire[0];
        rep_set[BIT_RIGHT] = rep_fire[1];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!reset_n || !deb_level[j]) begin
                rep_cnt[j]   <= '0;
                rep_phase[j] <= 1'b0;
            end else if (rep_fire[j]) begin
                rep_cnt[j]   <= RW'(1);
                rep_phase[j] <= 1'b1;
            end else begin
                rep_cnt[j] <= rep_cnt[j] + RW'(1);
            end
        end
    end
`else
    assign rep_set = '0;
`endif

    always_comb begin
        grav_shift = 32'(GRAVITY_BASE) >> level;
        grav_limit = (grav_shift > 32'd1) ? GW'(grav_shift - 32'd1) : '0;
        grav_tick  = (grav_cnt >= grav_limit);
        grav_set   = '0;
        grav_set[BIT_DOWN] = grav_tick;
    end

    assign set_mask = uart_set | btn_set | rep_set | grav_set;

    // A stalled core only ever gets user commands; gravity waits for ready.
    always_comb begin
        non_down           = pending;
        non_down[BIT_DOWN] = 1'b0;
        stall_hit    = (stall_cnt >= SW'(STALL_CYCLES));
        issue_normal = ready && (|pending);
        issue_stall  = !ready && stall_hit && (|non_down);
        issue        = (ctrl == NONE) && (issue_normal || issue_stall);
        issue_cmd    = pick_cmd(issue_normal ? pending : non_down);
        clr_mask     = issue ? cmd_bit(issue_cmd) : '0;
        down_issued  = issue && (issue_cmd == DOWN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl      <= NONE;
            pending   <= '0;
            grav_cnt  <= '0;
            stall_cnt <= '0;
            deb_prev  <= '0;
        end else begin
            deb_prev <= deb_level;
            ctrl     <= issue ? issue_cmd : NONE;
            pending  <= (pending & ~clr_mask) | set_mask;

            // The issue cycle itself is cycle 0 of the new gravity interval.
            if (down_issued)    grav_cnt <= GW'(1);
            else if (grav_tick) grav_cnt <= '0;
            else                grav_cnt <= grav_cnt + GW'(1);

            if (ready || issue_stall) stall_cnt <= '0;
            else if (!stall_hit)      stall_cnt <= stall_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb/tb_tetris_input_ctrl.sv - directed self-checking bench for tetris_input_ctrl
module tb_tetris_input_ctrl;
    import control_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  btn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  level;
    logic        ready;
    control_type ctrl;

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int cr = 0;
    int cnt_cmd [9];
    int first_t [9];
    int down_t [$];
    int right_t [$];
    int consec = 0;
    control_type prev_ctrl = NONE;

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .GRAVITY_BASE   (64),
        .STALL_CYCLES   (16),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .level   (level),
        .ready   (ready),
        .ctrl    (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ctrl != NONE) begin
            cnt_cmd[int'(ctrl)]++;
            if (first_t[int'(ctrl)] < 0) first_t[int'(ctrl)] = cyc;
            if (ctrl == DOWN) down_t.push_back(cyc);
            if (ctrl == RIGHT) right_t.push_back(cyc);
            if (prev_ctrl != NONE) consec++;
        end
        prev_ctrl = ctrl;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 9; i++) begin
            cnt_cmd[i] = 0;
            first_t[i] = -1;
        end
        down_t.delete();
        right_t.delete();
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 1; i < 9; i++) s += cnt_cmd[i];
        return s;
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        btn      = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        level    = '0;
        ready    = 1'b0;
        tick(2);
        reset_n = 1'b1;
        cr = cyc;
        clear_mon();
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (ctrl !== NONE) begin
            failures++;
            $display("FAIL reset_ctrl: got %0d, expected %0d", int'(ctrl), int'(NONE));
        end
        ready = 1'b1;
        tick(30);
        tests++;
        if (total_pulses() !== 0) begin
            failures++;
            $display("FAIL reset_idle: got %0d pulses, expected 0", total_pulses());
        end
    endtask

    task automatic test_uart_keys();
        logic [7:0]  keys  [8] = '{8'h61, 8'h64, 8'h73, 8'h20, 8'h63, 8'h77, 8'h7a, 8'h62};
        control_type exp_c [8] = '{LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR};
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_rx(keys[k]);
            tick(1);
            tests++;
            if (ctrl !== exp_c[k]) begin
                failures++;
                $display("FAIL uart_key_%0d: got %0d, expected %0d", k, int'(ctrl), int'(exp_c[k]));
            end
            tick(1);
            tests++;
            if (ctrl !== NONE) begin
                failures++;
                $display("FAIL uart_one_cycle_%0d: got %0d, expected %0d", k, int'(ctrl), int'(NONE));
            end
        end
        clear_mon();
        send_rx(8'h71);
        tick(4);
        tests++;
        if (total_pulses() !== 0) begin
            failures++;
            $display("FAIL uart_ignored: got %0d pulses, expected 0", total_pulses());
        end
    endtask

    task automatic test_buttons();
        control_type bmap [4] = '{LEFT, RIGHT, ROTATE, DROP};
        int c0;
        for (int b = 0; b < 4; b++) begin
            do_reset();
            ready = 1'b1;
            c0 = cyc;
            btn[b] = 1'b1;
            tick(10);
            btn[b] = 1'b0;
            tick(12);
            tests++;
            if (cnt_cmd[int'(bmap[b])] !== 1 || total_pulses() !== 1) begin
                failures++;
                $display("FAIL btn_%0d_count: got %0d of cmd, %0d total, expected 1 and 1",
                         b, cnt_cmd[int'(bmap[b])], total_pulses());
            end
            tests++;
            if (first_t[int'(bmap[b])] - c0 !== 8) begin
                failures++;
                $display("FAIL btn_%0d_latency: got %0d, expected 8", b, first_t[int'(bmap[b])] - c0);
            end
        end
        clear_mon();
        btn[0] = 1'b1;
        tick(2);
        btn[0] = 1'b0;
        tick(12);
        tests++;
        if (cnt_cmd[int'(LEFT)] !== 0) begin
            failures++;
            $display("FAIL btn_glitch: got %0d pulses, expected 0", cnt_cmd[int'(LEFT)]);
        end
    endtask

    task automatic test_priority();
        logic [7:0]  keys  [8] = '{8'h61, 8'h64, 8'h73, 8'h20, 8'h63, 8'h77, 8'h7a, 8'h62};
        control_type order [8] = '{DROP, HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, BAR, DOWN};
        do_reset();
        send_rx(8'h77);
        send_rx(8'h20);
        tick(2);
        pulse_ready();
        tests++;
        if (ctrl !== DROP) begin
            failures++;
            $display("FAIL prio_first: got %0d, expected %0d", int'(ctrl), int'(DROP));
        end
        tick(3);
        tests++;
        if (ctrl !== NONE) begin
            failures++;
            $display("FAIL prio_wait: got %0d, expected %0d", int'(ctrl), int'(NONE));
        end
        pulse_ready();
        tests++;
        if (ctrl !== ROTATE) begin
            failures++;
            $display("FAIL prio_second: got %0d, expected %0d", int'(ctrl), int'(ROTATE));
        end
        tick(1);
        for (int k = 0; k < 8; k++) send_rx(keys[k]);
        tick(1);
        for (int k = 0; k < 8; k++) begin
            pulse_ready();
            tests++;
            if (ctrl !== order[k]) begin
                failures++;
                $display("FAIL prio_order_%0d: got %0d, expected %0d", k, int'(ctrl), int'(order[k]));
            end
            tick(1);
        end
    endtask

    task automatic test_gravity();
        int exp_d [6] = '{17, 33, 49, 65, 72, 88};
        do_reset();
        level = 4'd2;
        ready = 1'b1;
        tick(70);
        send_rx(8'h73);
        tick(25);
        tests++;
        if (down_t.size() !== 6) begin
            failures++;
            $display("FAIL grav_count: got %0d, expected 6", down_t.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < down_t.size()) begin
                tests++;
                if (down_t[i] - cr !== exp_d[i]) begin
                    failures++;
                    $display("FAIL grav_time_%0d: got %0d, expected %0d", i, down_t[i] - cr, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        send_rx(8'h63);
        tick(100);
        tests++;
        if (first_t[int'(HOLD)] - cr !== 17) begin
            failures++;
            $display("FAIL stall_hold_time: got %0d, expected 17", first_t[int'(HOLD)] - cr);
        end
        tests++;
        if (cnt_cmd[int'(HOLD)] !== 1 || cnt_cmd[int'(DOWN)] !== 0) begin
            failures++;
            $display("FAIL stall_counts: got hold %0d down %0d, expected 1 and 0",
                     cnt_cmd[int'(HOLD)], cnt_cmd[int'(DOWN)]);
        end
        ready = 1'b1;
        tick(1);
        tests++;
        if (ctrl !== DOWN) begin
            failures++;
            $display("FAIL stall_gravity_release: got %0d, expected %0d", int'(ctrl), int'(DOWN));
        end
    endtask

    task automatic test_hold();
        int exp_r [$];
        int c0;
`ifdef TETRIS_AUTO_REPEAT_EN
        exp_r = '{8, 28, 36, 44, 52};
`else
        exp_r = '{8};
`endif
        do_reset();
        ready = 1'b1;
        c0 = cyc;
        btn[1] = 1'b1;
        tick(50);
        btn[1] = 1'b0;
        tick(20);
        tests++;
        if (right_t.size() !== exp_r.size()) begin
            failures++;
            $display("FAIL hold_count: got %0d, expected %0d", right_t.size(), exp_r.size());
        end
        for (int i = 0; i < exp_r.size(); i++) begin
            if (i < right_t.size()) begin
                tests++;
                if (right_t[i] - c0 !== exp_r[i]) begin
                    failures++;
                    $display("FAIL hold_time_%0d: got %0d, expected %0d", i, right_t[i] - c0, exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        control_type exp_seq [7] = '{LEFT, NONE, RIGHT, NONE, LEFT, NONE, LEFT};
        control_type got_seq [7];
        do_reset();
        ready    = 1'b1;
        rx_data  = 8'h61;
        rx_valid = 1'b1;
        tick(1);
        rx_data = 8'h64;
        tick(1);
        rx_valid = 1'b0;
        got_seq[0] = ctrl;
        tick(1);
        got_seq[1] = ctrl;
        tick(1);
        got_seq[2] = ctrl;
        tick(1);
        rx_data  = 8'h61;
        rx_valid = 1'b1;
        got_seq[3] = ctrl;
        tick(2);
        rx_valid = 1'b0;
        got_seq[4] = ctrl;
        tick(1);
        got_seq[5] = ctrl;
        tick(1);
        got_seq[6] = ctrl;
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got_seq[i] !== exp_seq[i]) begin
                failures++;
                $display("FAIL b2b_%0d: got %0d, expected %0d", i, int'(got_seq[i]), int'(exp_seq[i]));
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        send_rx(8'h20);
        tick(2);
        reset_n = 1'b0;
        tick(2);
        tests++;
        if (ctrl !== NONE) begin
            failures++;
            $display("FAIL rst_mid_ctrl: got %0d, expected %0d", int'(ctrl), int'(NONE));
        end
        reset_n = 1'b1;
        ready   = 1'b1;
        clear_mon();
        tick(20);
        tests++;
        if (cnt_cmd[int'(DROP)] !== 0 || total_pulses() !== 0) begin
            failures++;
            $display("FAIL rst_mid_discard: got drop %0d total %0d, expected 0 and 0",
                     cnt_cmd[int'(DROP)], total_pulses());
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        btn      = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        level    = '0;
        ready    = 1'b0;
        clear_mon();
        test_reset();
        test_uart_keys();
        test_buttons();
        test_priority();
        test_gravity();
        test_stall();
        test_hold();
        test_back_to_back();
        test_reset_pending();
        tests++;
        if (consec !== 0) begin
            failures++;
            $display("FAIL never_consecutive: got %0d, expected 0", consec);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
